// File: rtl/accum_sequencer.sv
// Multi-operand accumulation stage: sums N_SAMPLES operands through a ripple-carry chain.
// Optional SATURATE_EN macro clamps the accumulator to all-ones on carry-out instead of wrapping.
module accum_sequencer_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module accum_sequencer #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 6,
  parameter int N_SAMPLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_ovf,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] LAST = 8'(N_SAMPLES - 1);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [7:0]           count;
  logic                 ovf;

  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH:0]   carry;
  logic [ACC_WIDTH-1:0] acc_nxt;

  assign addend   = {{(ACC_WIDTH-WIDTH){1'b0}}, in_data};
  assign carry[0] = 1'b0;

  for (genvar g = 0; g < ACC_WIDTH; g++) begin : g_fa
    accum_sequencer_fa u_fa (
      .a  (acc[g]),
      .b  (addend[g]),
      .ci (carry[g]),
      .s  (sum[g]),
      .co (carry[g+1])
    );
  end

`ifdef SATURATE_EN
  // Once clamped, any further nonzero add carries again, so acc stays at all-ones.
  assign acc_nxt = carry[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum;
`else
  assign acc_nxt = sum;
`endif

  assign out_sum = acc;
  assign out_ovf = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= ACCUM;
          acc      <= '0;
          count    <= '0;
          ovf      <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
        end
        ACCUM: if (in_valid) begin
          acc   <= acc_nxt;
          ovf   <= ovf | carry[ACC_WIDTH];
          count <= count + 8'd1;
          if (count == LAST) begin
            state     <= DONE;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          // acc/ovf are kept so the last result remains observable until the next start.
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule
